// File: rtl/uart_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : uart_bus_responder
// Description : Memory-mapped 8N1 UART on the CPU's MEM-stage data bus.
//               TXD register (BASE)   : write starts a transmit, read returns
//                                       the last byte loaded.
//               RXD register (BASE+4) : read returns the received byte and
//                                       clears rx_ready / overrun.
//               CON register (BASE+8) : {ferr, ovr, tx_busy, rx_ready,
//                                       tx_done, rx_ie, tx_ie}; [1:0] R/W,
//                                       read clears tx_done and ferr.
// Ports       : clk   - system clock, rising edge
//               reset - asynchronous active-low reset
//               rd/wr - bus read/write strobes
//               addr  - byte address, wdata - write data
//               rdata - combinational read data, 0 when not selected
//               irq   - level interrupt (TX done / RX ready)
//               rxd   - serial input (idle high), txd - serial output
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bus_responder #(
    parameter int          CLK_HZ    = 50_000_000,
    parameter int          BAUD      = 9600,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    input  logic        rxd,
    output logic        txd
);

    localparam int c_DIV      = CLK_HZ / BAUD;
    localparam int c_TICK_RAW = c_DIV / 16;
    // A zero tick period would stall the receiver, so clamp to one cycle.
    localparam int c_TICK     = (c_TICK_RAW < 1) ? 1 : c_TICK_RAW;
    localparam int c_DIV_W    = $clog2(c_DIV + 1);
    localparam int c_TICK_W   = $clog2(c_TICK + 1);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    tx_state_e             tx_state_q, tx_state_d;
    logic [c_DIV_W-1:0]    tx_cnt_q, tx_cnt_d;
    logic [2:0]            tx_bit_q, tx_bit_d;
    logic [7:0]            tx_shreg_q, tx_shreg_d;
    logic [7:0]            tx_byte_q, tx_byte_d;
    logic                  tx_done_q, tx_done_d;
    logic [1:0]            con_ie_q, con_ie_d;

    logic                  rx_sync1_q, rx_sync1_d;
    logic                  rx_sync2_q, rx_sync2_d;
    logic                  rx_prev_q, rx_prev_d;
    rx_state_e             rx_state_q, rx_state_d;
    logic [c_TICK_W-1:0]   rx_div_q, rx_div_d;
    logic [3:0]            rx_tick_q, rx_tick_d;
    logic [2:0]            rx_bit_q, rx_bit_d;
    logic [7:0]            rx_shreg_q, rx_shreg_d;
    logic [7:0]            rx_data_q, rx_data_d;
    logic                  rx_ready_q, rx_ready_d;
    logic                  ovr_q, ovr_d;
    logic                  ferr_q, ferr_d;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic w_sel_txd, w_sel_rxd, w_sel_con;
    logic w_tx_busy, w_txd_wr, w_rxd_rd, w_con_rd, w_con_wr;
    logic [31:0] w_con_val;
    logic w_unused_wdata;

    assign w_sel_txd = (addr == BASE_ADDR);
    assign w_sel_rxd = (addr == BASE_ADDR + 32'd4);
    assign w_sel_con = (addr == BASE_ADDR + 32'd8);

    // Busy is derived from the TX state register, so it is still 1 during
    // the final STOP cycle and a write landing there is dropped.
    assign w_tx_busy = (tx_state_q != TX_IDLE);
    assign w_txd_wr  = wr & w_sel_txd & ~w_tx_busy;
    assign w_rxd_rd  = rd & w_sel_rxd;
    assign w_con_rd  = rd & w_sel_con;
    assign w_con_wr  = wr & w_sel_con;

    assign w_unused_wdata = ^wdata[31:8];

    assign w_con_val = {25'b0, ferr_q, ovr_q, w_tx_busy, rx_ready_q,
                        tx_done_q, con_ie_q[1], con_ie_q[0]};

    always_comb begin
        rdata = 32'b0;
        if (rd) begin
            if (w_sel_txd)      rdata = {24'b0, tx_byte_q};
            else if (w_sel_rxd) rdata = {24'b0, rx_data_q};
            else if (w_sel_con) rdata = w_con_val;
        end
    end

    assign irq = (con_ie_q[0] & tx_done_q) | (con_ie_q[1] & rx_ready_q);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic w_tx_bit_end;
    logic w_tx_done_set;

    assign w_tx_bit_end = (tx_cnt_q == c_DIV_W'(c_DIV - 1));

    always_comb begin
        tx_state_d    = tx_state_q;
        tx_cnt_d      = tx_cnt_q;
        tx_bit_d      = tx_bit_q;
        tx_shreg_d    = tx_shreg_q;
        tx_byte_d     = tx_byte_q;
        w_tx_done_set = 1'b0;
        txd           = 1'b1;

        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (w_txd_wr) begin
                    tx_shreg_d = wdata[7:0];
                    tx_byte_d  = wdata[7:0];
                    tx_bit_d   = 3'd0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                txd = 1'b0;
                if (w_tx_bit_end) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                txd = tx_shreg_q[0];
                if (w_tx_bit_end) begin
                    tx_cnt_d   = '0;
                    tx_shreg_d = {1'b0, tx_shreg_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (w_tx_bit_end) begin
                    tx_cnt_d      = '0;
                    w_tx_done_set = 1'b1;
                    tx_state_d    = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        // Setting the flag takes priority over clear-on-read in one edge.
        tx_done_d = tx_done_q;
        if (w_tx_done_set)  tx_done_d = 1'b1;
        else if (w_con_rd)  tx_done_d = 1'b0;

        con_ie_d = con_ie_q;
        if (w_con_wr) con_ie_d = wdata[1:0];
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic w_rx_fall, w_rx_tick, w_rx_set_ready, w_rx_set_ferr;

    assign w_rx_fall = rx_prev_q & ~rx_sync2_q;
    assign w_rx_tick = (rx_div_q == c_TICK_W'(c_TICK - 1));

    always_comb begin
        rx_sync1_d     = rxd;
        rx_sync2_d     = rx_sync1_q;
        rx_prev_d      = rx_sync2_q;
        rx_state_d     = rx_state_q;
        rx_div_d       = rx_div_q;
        rx_tick_d      = rx_tick_q;
        rx_bit_d       = rx_bit_q;
        rx_shreg_d     = rx_shreg_q;
        rx_data_d      = rx_data_q;
        w_rx_set_ready = 1'b0;
        w_rx_set_ferr  = 1'b0;

        if (rx_state_q == RX_IDLE) begin
            rx_div_d  = '0;
            rx_tick_d = 4'd0;
            rx_bit_d  = 3'd0;
            if (w_rx_fall) rx_state_d = RX_START;
        end else begin
            rx_div_d = w_rx_tick ? '0 : rx_div_q + 1'b1;
        end

        case (rx_state_q)
            RX_START: begin
                // Mid-start-bit check rejects glitches shorter than half a bit.
                if (w_rx_tick) begin
                    if (rx_tick_q == 4'd7) begin
                        rx_tick_d  = 4'd0;
                        rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_tick_d = rx_tick_q + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (w_rx_tick) begin
                    rx_tick_d = rx_tick_q + 4'd1;
                    if (rx_tick_q == 4'd15) begin
                        rx_shreg_d = {rx_sync2_q, rx_shreg_q[7:1]};
                        rx_bit_d   = rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (w_rx_tick) begin
                    rx_tick_d = rx_tick_q + 4'd1;
                    if (rx_tick_q == 4'd15) begin
                        rx_state_d = RX_IDLE;
                        if (rx_sync2_q) begin
                            rx_data_d      = rx_shreg_q;
                            w_rx_set_ready = 1'b1;
                        end else begin
                            w_rx_set_ferr = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase

        rx_ready_d = rx_ready_q;
        if (w_rx_set_ready)  rx_ready_d = 1'b1;
        else if (w_rxd_rd)   rx_ready_d = 1'b0;

        ovr_d = ovr_q;
        if (w_rx_set_ready && rx_ready_q) ovr_d = 1'b1;
        else if (w_rxd_rd)                ovr_d = 1'b0;

        ferr_d = ferr_q;
        if (w_rx_set_ferr)   ferr_d = 1'b1;
        else if (w_con_rd)   ferr_d = 1'b0;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_shreg_q <= 8'd0;
            tx_byte_q  <= 8'd0;
            tx_done_q  <= 1'b0;
            con_ie_q   <= 2'd0;
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_div_q   <= '0;
            rx_tick_q  <= 4'd0;
            rx_bit_q   <= 3'd0;
            rx_shreg_q <= 8'd0;
            rx_data_q  <= 8'd0;
            rx_ready_q <= 1'b0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shreg_q <= tx_shreg_d;
            tx_byte_q  <= tx_byte_d;
            tx_done_q  <= tx_done_d;
            con_ie_q   <= con_ie_d;
            rx_sync1_q <= rx_sync1_d;
            rx_sync2_q <= rx_sync2_d;
            rx_prev_q  <= rx_prev_d;
            rx_state_q <= rx_state_d;
            rx_div_q   <= rx_div_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_shreg_q <= rx_shreg_d;
            rx_data_q  <= rx_data_d;
            rx_ready_q <= rx_ready_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
        end
    end

endmodule
`default_nettype wire
